maxpool2x2_layer3: RTL and testbench

//  2x2, stride-2 signed max-pooling stage fed by the layer-3 conv output stream
//  (valid_out of control_layer3, plus the bias-stage data word).
//  - Consumes one WIDTH x WIDTH feature map in raster order, one pixel per valid_in.
//  - Emits (WIDTH/2) x (WIDTH/2) pooled pixels in raster order to the next conv layer's padding control.

---
 rtl/maxpool2x2_layer3_pkg.sv | 13 +
 rtl/maxpool2x2_layer3_if.sv | 35 +++
 rtl/maxpool_line_buffer.sv | 28 ++
 rtl/maxpool2x2_layer3.sv | 126 ++++++++++++
 tb/tb_maxpool2x2_layer3.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/maxpool2x2_layer3_pkg.sv
// Shared defaults and helpers for the layer-3 2x2 max-pooling stage.
package maxpool2x2_layer3_pkg;

  localparam int LAYER3_WIDTH  = 5;
  localparam int LAYER3_DATA_W = 16;
  localparam int LAYER3_CNT_W  = 32;

  // Address width for a buffer of `depth` entries; never narrower than one bit.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/maxpool2x2_layer3_if.sv
// Pixel stream into the pooling stage and pooled stream out of it.
interface maxpool2x2_layer3_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 32
);

  logic                     valid_in;
  logic signed [DATA_W-1:0] data_in;
  logic                     valid_out;
  logic signed [DATA_W-1:0] data_out;
  logic [CNT_W-1:0]         out_col;
  logic [CNT_W-1:0]         out_row;
  logic                     frame_done;

  modport master (
    output valid_in,
    output data_in,
    input  valid_out,
    input  data_out,
    input  out_col,
    input  out_row,
    input  frame_done
  );

  modport slave (
    input  valid_in,
    input  data_in,
    output valid_out,
    output data_out,
    output out_col,
    output out_row,
    output frame_done
  );

endinterface

// File: rtl/maxpool_line_buffer.sv
// One row of horizontal pair maxima; synchronous write, combinational read.
module maxpool_line_buffer
  import maxpool2x2_layer3_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 16,
  localparam int ADDR_W = idx_width(DEPTH)
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic signed [DATA_W-1:0] rd_data
);

  logic signed [DATA_W-1:0] mem_r [DEPTH];

  // Store the even-row pair maximum for its window column.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/maxpool2x2_layer3.sv
// 2x2 stride-2 signed max pooling over a WIDTH x WIDTH raster-order feature map.
module maxpool2x2_layer3
  import maxpool2x2_layer3_pkg::*;
#(
  parameter int WIDTH  = LAYER3_WIDTH,
  parameter int DATA_W = LAYER3_DATA_W,
  parameter int CNT_W  = LAYER3_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  maxpool2x2_layer3_if.slave bus
);

  localparam int P     = WIDTH / 2;
  localparam int IDX_W = idx_width(P);
  localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ACTIVE_LIM = CNT_W'(2 * P);

  logic [CNT_W-1:0]         in_col_r;
  logic [CNT_W-1:0]         in_row_r;
  logic signed [DATA_W-1:0] h_reg_r;
  logic                     valid_out_r;
  logic signed [DATA_W-1:0] data_out_r;
  logic [CNT_W-1:0]         out_col_r;
  logic [CNT_W-1:0]         out_row_r;
  logic                     frame_done_r;

  logic                     col_last_s;
  logic                     row_last_s;
  logic                     active_s;
  logic                     col_odd_s;
  logic                     row_odd_s;
  logic                     h_load_s;
  logic                     lb_wr_s;
  logic                     emit_s;
  logic                     frame_end_s;
  logic [IDX_W-1:0]         lb_addr_s;
  logic signed [DATA_W-1:0] pair_s;
  logic signed [DATA_W-1:0] lb_rd_s;
  logic signed [DATA_W-1:0] pool_s;

  function automatic logic signed [DATA_W-1:0] smax(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  // Decode the current raster position and form the pair / window maxima.
  always_comb begin
    col_last_s  = (in_col_r == LAST_IDX);
    row_last_s  = (in_row_r == LAST_IDX);
    active_s    = (in_col_r < ACTIVE_LIM) && (in_row_r < ACTIVE_LIM);
    col_odd_s   = in_col_r[0];
    row_odd_s   = in_row_r[0];
    lb_addr_s   = in_col_r[IDX_W:1];
    h_load_s    = bus.valid_in && active_s && !col_odd_s;
    lb_wr_s     = bus.valid_in && active_s && col_odd_s && !row_odd_s;
    emit_s      = bus.valid_in && active_s && col_odd_s && row_odd_s;
    frame_end_s = bus.valid_in && col_last_s && row_last_s;
    pair_s      = smax(h_reg_r, bus.data_in);
    pool_s      = smax(lb_rd_s, pair_s);
  end

  maxpool_line_buffer #(
    .DEPTH  (P),
    .DATA_W (DATA_W)
  ) u_line_buffer (
    .clk     (clk),
    .wr_en   (lb_wr_s),
    .wr_addr (lb_addr_s),
    .wr_data (pair_s),
    .rd_addr (lb_addr_s),
    .rd_data (lb_rd_s)
  );

  // Raster position counters; the last pixel of a frame wraps straight to (0,0).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_col_r <= '0;
      in_row_r <= '0;
    end else if (bus.valid_in) begin
      if (col_last_s) begin
        in_col_r <= '0;
        in_row_r <= row_last_s ? '0 : in_row_r + CNT_W'(1);
      end else begin
        in_col_r <= in_col_r + CNT_W'(1);
      end
    end
  end

  // Left pixel of each horizontal pair.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_reg_r <= '0;
    end else if (h_load_s) begin
      h_reg_r <= bus.data_in;
    end
  end

  // Pooled result registers; data and coordinates hold between pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_out_r  <= 1'b0;
      data_out_r   <= '0;
      out_col_r    <= '0;
      out_row_r    <= '0;
      frame_done_r <= 1'b0;
    end else begin
      valid_out_r  <= emit_s;
      frame_done_r <= frame_end_s;
      if (emit_s) begin
        data_out_r <= pool_s;
        out_col_r  <= in_col_r >> 1;
        out_row_r  <= in_row_r >> 1;
      end
    end
  end

  assign bus.valid_out  = valid_out_r;
  assign bus.data_out   = data_out_r;
  assign bus.out_col    = out_col_r;
  assign bus.out_row    = out_row_r;
  assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_maxpool2x2_layer3.sv
// Directed bench: WIDTH=4 and WIDTH=5 instances, hand-computed pooled values.
module tb_maxpool2x2_layer3;

  typedef logic signed [15:0] pool_t [4];
  typedef logic signed [15:0] map16_t [16];

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic signed [15:0] last4;
  logic signed [15:0] last5;

  maxpool2x2_layer3_if #(.DATA_W(16), .CNT_W(32)) bus4 ();
  maxpool2x2_layer3_if #(.DATA_W(16), .CNT_W(32)) bus5 ();

  maxpool2x2_layer3 #(.WIDTH(4), .DATA_W(16), .CNT_W(32)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  maxpool2x2_layer3 #(.WIDTH(5), .DATA_W(16), .CNT_W(32)) dut5 (
    .clk (clk),
    .rst (rst),
    .bus (bus5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic v, input logic signed [15:0] d);
    bus4.valid_in = (w == 4) ? v : 1'b0;
    bus4.data_in  = d;
    bus5.valid_in = (w == 5) ? v : 1'b0;
    bus5.data_in  = d;
  endtask

  task automatic sample(input int w, output logic v, output logic signed [15:0] d,
                        output logic [31:0] c, output logic [31:0] r, output logic fd);
    if (w == 4) begin
      v = bus4.valid_out; d = bus4.data_out; c = bus4.out_col; r = bus4.out_row; fd = bus4.frame_done;
    end else begin
      v = bus5.valid_out; d = bus5.data_out; c = bus5.out_col; r = bus5.out_row; fd = bus5.frame_done;
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int w = 4; w <= 5; w++) begin
      logic v, fd;
      logic signed [15:0] d;
      logic [31:0] c, r;
      sample(w, v, d, c, r, fd);
      chk({tag, "_valid"}, 64'(v), 64'(1'b0));
      chk({tag, "_data"}, 64'(d), 64'(16'sd0));
      chk({tag, "_col"}, 64'(c), 64'(32'd0));
      chk({tag, "_row"}, 64'(r), 64'(32'd0));
      chk({tag, "_fdone"}, 64'(fd), 64'(1'b0));
    end
  endtask

  // One accepted pixel, then the outputs after the edge that consumed it.
  task automatic feed(input int w, input int idx, input logic signed [15:0] d,
                      input pool_t pool, input string tag);
    int row, col, p;
    logic ev, v, fd;
    logic signed [15:0] od, exp_d, held;
    logic [31:0] oc, orow;
    row = idx / w;
    col = idx % w;
    p   = w / 2;
    @(negedge clk);
    drive(w, 1'b1, d);
    @(posedge clk);
    #1;
    sample(w, v, od, oc, orow, fd);
    ev = (row < 2 * p) && (col < 2 * p) && (row % 2 == 1) && (col % 2 == 1);
    held = (w == 4) ? last4 : last5;
    chk($sformatf("%s_valid_px%0d", tag, idx), 64'(v), 64'(ev));
    if (ev) begin
      exp_d = pool[(row / 2) * p + col / 2];
      chk($sformatf("%s_data_px%0d", tag, idx), 64'(od), 64'(exp_d));
      chk($sformatf("%s_col_px%0d", tag, idx), 64'(oc), 64'(col / 2));
      chk($sformatf("%s_row_px%0d", tag, idx), 64'(orow), 64'(row / 2));
      if (w == 4) last4 = exp_d;
      else last5 = exp_d;
    end else begin
      chk($sformatf("%s_hold_px%0d", tag, idx), 64'(od), 64'(held));
    end
    chk($sformatf("%s_fdone_px%0d", tag, idx), 64'(fd), 64'(idx == w * w - 1));
  endtask

  // Idle cycle with junk on data_in; nothing may move.
  task automatic gap(input int w, input string tag);
    logic v, fd;
    logic signed [15:0] od;
    logic [31:0] oc, orow;
    @(negedge clk);
    drive(w, 1'b0, 16'sh7fff);
    @(posedge clk);
    #1;
    sample(w, v, od, oc, orow, fd);
    chk({tag, "_gap_valid"}, 64'(v), 64'(1'b0));
    chk({tag, "_gap_fdone"}, 64'(fd), 64'(1'b0));
    chk({tag, "_gap_hold"}, 64'(od), 64'((w == 4) ? last4 : last5));
  endtask

  initial begin
    pool_t  p_ramp4, p_ramp4_f2, p_neg, p_ramp5, p_fresh;
    map16_t neg_map;
    total = 0;
    bad   = 0;
    last4 = 16'sd0;
    last5 = 16'sd0;
    p_ramp4    = '{16'sd5, 16'sd7, 16'sd13, 16'sd15};
    p_ramp4_f2 = '{16'sd105, 16'sd107, 16'sd113, 16'sd115};
    p_neg      = '{-16'sd2, -16'sd3, -16'sd4, -16'sd1};
    p_ramp5    = '{16'sd6, 16'sd8, 16'sd16, 16'sd18};
    p_fresh    = '{16'sd205, 16'sd207, 16'sd213, 16'sd215};
    neg_map    = '{-16'sd2,  -16'sd16, -16'sd13, -16'sd3,
                   -16'sd15, -16'sd14, -16'sd12, -16'sd11,
                   -16'sd10, -16'sd9,  -16'sd7,  -16'sd6,
                   -16'sd4,  -16'sd8,  -16'sd5,  -16'sd1};

    rst = 1'b0;
    drive(4, 1'b0, 16'sd0);
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Ramp frame followed back-to-back by the 100+i frame.
    for (int i = 0; i < 16; i++) feed(4, i, 16'(i), p_ramp4, "ramp4");
    for (int i = 0; i < 16; i++) feed(4, i, 16'(100 + i), p_ramp4_f2, "b2b");
    gap(4, "after_b2b");

    // All-negative map, window maxima in four different corners.
    for (int i = 0; i < 16; i++) feed(4, i, neg_map[i], p_neg, "neg");
    gap(4, "after_neg");

    // Ramp frame with idle gaps between pixels.
    for (int i = 0; i < 16; i++) begin
      feed(4, i, 16'(i), p_ramp4, "gappy");
      repeat ((i % 2 == 0) ? 1 : int'($urandom_range(0, 2))) gap(4, "gappy");
    end

    // Odd width: last column and row are dropped.
    for (int i = 0; i < 25; i++) feed(5, i, 16'(i), p_ramp5, "ramp5");
    gap(5, "after_ramp5");

    // Abort a frame after pixel 9, then a clean frame.
    for (int i = 0; i < 10; i++) feed(4, i, 16'(i), p_ramp4, "abort");
    @(negedge clk);
    drive(4, 1'b1, 16'sd999);
    rst = 1'b0;
    #1;
    chk_zero("async_rst");
    @(posedge clk);
    #1;
    chk_zero("held_rst");
    @(negedge clk);
    drive(4, 1'b0, 16'sd0);
    rst   = 1'b1;
    last4 = 16'sd0;
    last5 = 16'sd0;
    for (int i = 0; i < 16; i++) feed(4, i, 16'(200 + i), p_fresh, "fresh");
    gap(4, "after_fresh");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
